// File: rtl/usb_ft232h_pkg.sv
// Shared types and defaults for the FT232H synchronous-FIFO bridge.
package usb_ft232h_pkg;

  localparam int DEFAULT_DEPTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    RD_OE,
    RD,
    TURN,
    WR
  } state_e;

endpackage

// File: rtl/usb_ft232h_if_sync_fifo.sv
// Single-clock FWFT FIFO with used-word count; pushes while full and pops while
// empty are dropped. Head is valid the cycle after the first push.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 512,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] used_o,
  output logic          full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] used_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push_i && (used_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (used_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      used_q <= used_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage carries no reset; the count alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign used_o = used_q;
  assign full_o = (used_q == CW'(DEPTH));

endmodule

// File: rtl/usb_ft232h_if.sv
// FT232H 245 synchronous-FIFO bridge: RX/TX FIFOs plus a round-robin handshake FSM.
// Strobes decode from the state register; RD# drops only while two RX slots remain.
module usb_ft232h_if
  import usb_ft232h_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          usb_clk_i,
  input  logic          rst_i,
  inout  wire  [7:0]    usb_data_io,
  input  logic          usb_rxf_n_i,
  input  logic          usb_txe_n_i,
  output logic          usb_rd_n_o,
  output logic          usb_wr_n_o,
  output logic          usb_oe_n_o,
  input  logic          rxf_rdreq_i,
  output logic [7:0]    rxf_rddata_o,
  output logic [CW-1:0] rxf_rdusedw_o,
  input  logic          txe_wrreq_i,
  input  logic [7:0]    txe_wrdata_i,
  output logic [CW-1:0] txe_wrusedw_o,
  output logic          txe_wrfull_o
);

  state_e        state_q;
  logic          last_rd_q;
  logic [CW-1:0] rx_used;
  logic [CW-1:0] tx_used;
  logic [7:0]    tx_head;
  logic          rx_full_unused;
  logic          rx_ok;
  logic          tx_ok;
  logic          rx_push;
  logic          tx_pop;

  assign rx_ok   = !usb_rxf_n_i && (rx_used <= CW'(DEPTH - 2));
  assign tx_ok   = !usb_txe_n_i && (tx_used != '0);
  assign rx_push = (state_q == RD) && !usb_rxf_n_i;
  assign tx_pop  = (state_q == WR) && !usb_txe_n_i;

  sync_fifo #(.W(8), .DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk_i      (usb_clk_i),
    .rst_i      (rst_i),
    .push_i     (rx_push),
    .push_dat_i (usb_data_io),
    .pop_i      (rxf_rdreq_i),
    .head_o     (rxf_rddata_o),
    .used_o     (rx_used),
    .full_o     (rx_full_unused)
  );

  sync_fifo #(.W(8), .DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk_i      (usb_clk_i),
    .rst_i      (rst_i),
    .push_i     (txe_wrreq_i),
    .push_dat_i (txe_wrdata_i),
    .pop_i      (tx_pop),
    .head_o     (tx_head),
    .used_o     (tx_used),
    .full_o     (txe_wrfull_o)
  );

  // last_rd_q: 1 when the previous burst was a read, so a tie goes to the write.
  always_ff @(posedge usb_clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_ok && (!tx_ok || !last_rd_q)) begin
            state_q   <= RD_OE;
            last_rd_q <= 1'b1;
          end else if (tx_ok) begin
            state_q   <= WR;
            last_rd_q <= 1'b0;
          end
        end
        RD_OE:   state_q <= RD;
        RD:      if (!rx_ok) state_q <= TURN;
        TURN:    state_q <= IDLE;
        WR:      if (usb_txe_n_i || (tx_used <= CW'(1))) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign usb_oe_n_o    = !((state_q == RD_OE) || (state_q == RD));
  assign usb_rd_n_o    = !(state_q == RD);
  assign usb_wr_n_o    = !(state_q == WR);
  assign usb_data_io   = (state_q == WR) ? tx_head : 8'bz;
  assign rxf_rdusedw_o = rx_used;
  assign txe_wrusedw_o = tx_used;

endmodule

// File: tb/tb_usb_ft232h_if.sv
// Bench for usb_ft232h_if with DEPTH=8: FT232H chip model, scoreboard queues and a
// negedge monitor that checks every accepted TX byte and every popped RX byte.
module tb_usb_ft232h_if;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxf_n = 1'b1;
  logic          txe_n = 1'b1;
  logic          rdreq = 1'b0;
  logic          wrreq = 1'b0;
  logic [7:0]    wrdata = 8'h00;
  logic [7:0]    bus_drv = 8'h00;
  wire  [7:0]    usb_data;
  wire           rd_n, wr_n, oe_n, wrfull;
  wire  [7:0]    rddata;
  wire  [CW-1:0] rdusedw, wrusedw;

  int total = 0;
  int bad = 0;
  logic [7:0] chip_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int pause_at = -1;
  int wr_cycles = 0;
  int tx_acc = 0;
  int rd_bursts = 0;
  logic [15:0] seq = 16'h0;
  logic cap_pending = 1'b0;
  logic prev_rd_n = 1'b1, prev_wr_n = 1'b1, prev_oe_n = 1'b1;

  always #5 clk = ~clk;

  assign usb_data = !oe_n ? bus_drv : 8'bz;

  usb_ft232h_if #(.DEPTH(DEPTH), .CW(CW)) dut (
    .usb_clk_i     (clk),
    .rst_i         (rst),
    .usb_data_io   (usb_data),
    .usb_rxf_n_i   (rxf_n),
    .usb_txe_n_i   (txe_n),
    .usb_rd_n_o    (rd_n),
    .usb_wr_n_o    (wr_n),
    .usb_oe_n_o    (oe_n),
    .rxf_rdreq_i   (rdreq),
    .rxf_rddata_o  (rddata),
    .rxf_rdusedw_o (rdusedw),
    .txe_wrreq_i   (wrreq),
    .txe_wrdata_i  (wrdata),
    .txe_wrusedw_o (wrusedw),
    .txe_wrfull_o  (wrfull)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Chip model: a byte leaves the chip queue once an edge with RD# and RXF# low has passed.
  always @(negedge clk) begin
    logic pause;
    pause = 1'b0;
    if (cap_pending) begin
      void'(chip_rx.pop_front());
      pause = (chip_rx.size() == pause_at);
    end
    rxf_n       = pause || (chip_rx.size() == 0);
    bus_drv     = (chip_rx.size() != 0) ? chip_rx[0] : 8'h00;
    cap_pending = !rd_n && !rxf_n;
  end

  // Monitor: scoreboard pops plus burst-shape checks.
  always @(negedge clk) begin
    if (rst) begin
      seq = 16'h0;
    end else begin
      if (!rd_n && prev_rd_n) begin
        seq = {seq[13:0], 2'b01};
        rd_bursts++;
        check("oe_lead_rd", int'(prev_oe_n), 0);
      end
      if (!wr_n && prev_wr_n) seq = {seq[13:0], 2'b10};
      if (rd_n && !prev_rd_n) begin
        check("turnaround", int'({oe_n, wr_n}), 3);
        check("rx_no_overflow", int'(rdusedw <= CW'(DEPTH)), 1);
      end
      if (!wr_n) wr_cycles++;
      if (!wr_n && !txe_n) begin
        tx_acc++;
        if (exp_tx.size() == 0) check("tx_extra_byte", int'(usb_data), -1);
        else check("tx_byte", int'(usb_data), int'(exp_tx.pop_front()));
      end
      if (rdreq && (rdusedw != 0)) begin
        if (exp_rx.size() == 0) check("rx_extra_byte", int'(rddata), -1);
        else check("rx_byte", int'(rddata), int'(exp_rx.pop_front()));
      end
    end
    prev_rd_n = rd_n;
    prev_wr_n = wr_n;
    prev_oe_n = oe_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit accept);
    wrreq  = 1'b1;
    wrdata = b;
    if (accept) exp_tx.push_back(b);
    tick();
    wrreq = 1'b0;
  endtask

  task automatic load_chip(input logic [7:0] b);
    chip_rx.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic pop_rx(input int n);
    for (int i = 0; i < n; i++) begin
      rdreq = 1'b1;
      tick();
    end
    rdreq = 1'b0;
  endtask

  task automatic drain_rx();
    int n;
    n = 0;
    while (exp_rx.size() != 0 && n < 300) begin
      rdreq = (rdusedw != 0);
      tick();
      n++;
    end
    rdreq = 1'b0;
  endtask

  initial begin
    int base, n;
    logic [7:0] b;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rd_n", int'(rd_n), 1);
    check("rst_wr_n", int'(wr_n), 1);
    check("rst_oe_n", int'(oe_n), 1);
    check("rst_rdusedw", int'(rdusedw), 0);
    check("rst_wrusedw", int'(wrusedw), 0);
    check("rst_wrfull", int'(wrfull), 0);
    rst = 1'b0;
    tick();

    // RX burst of four bytes
    load_chip(8'hA1); load_chip(8'hA2); load_chip(8'hA3); load_chip(8'hA4);
    repeat (12) tick();
    check("rx_burst_used", int'(rdusedw), 4);
    pop_rx(4);
    check("rx_after_pop_used", int'(rdusedw), 0);
    pop_rx(1);
    check("rx_pop_empty_used", int'(rdusedw), 0);

    // TX burst of three bytes
    txe_n = 1'b0;
    base = wr_cycles;
    push_tx(8'h10, 1'b1); push_tx(8'h20, 1'b1); push_tx(8'h30, 1'b1);
    repeat (8) tick();
    check("tx_wr_cycles", wr_cycles - base, 3);
    check("tx_used_zero", int'(wrusedw), 0);

    // TXE# stall mid-burst
    txe_n = 1'b1;
    push_tx(8'h41, 1'b1); push_tx(8'h42, 1'b1); push_tx(8'h43, 1'b1); push_tx(8'h44, 1'b1);
    base = tx_acc;
    txe_n = 1'b0;
    n = 0;
    while ((tx_acc - base) < 2 && n < 20) begin
      tick();
      n++;
    end
    check("stall_two_sent", tx_acc - base, 2);
    txe_n = 1'b1;
    @(negedge clk);
    check("stall_wr_n", int'(wr_n), 0);
    check("stall_bus_held", int'(usb_data), 8'h43);
    check("stall_no_pop", int'(wrusedw), 2);
    tick();
    tick();
    txe_n = 1'b0;
    repeat (8) tick();
    check("stall_used_zero", int'(wrusedw), 0);
    txe_n = 1'b1;

    // RX backpressure: chip keeps RXF# low with twelve bytes
    for (int i = 0; i < 12; i++) begin
      b = 8'hB0 + 8'(i);
      load_chip(b);
    end
    repeat (20) tick();
    check("bp_full_used", int'(rdusedw), 8);
    check("bp_chip_left", chip_rx.size(), 4);
    base = rd_bursts;
    pop_rx(2);
    repeat (15) tick();
    check("bp_refill_used", int'(rdusedw), 8);
    check("bp_new_burst", rd_bursts - base, 1);
    check("bp_chip_left2", chip_rx.size(), 2);
    drain_rx();
    repeat (10) tick();
    check("bp_drained_used", int'(rdusedw), 0);

    // Arbitration after a fresh reset: read first, then write, then read
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    push_tx(8'hD1, 1'b1); push_tx(8'hD2, 1'b1);
    pause_at = 2;
    load_chip(8'hC1); load_chip(8'hC2); load_chip(8'hC3); load_chip(8'hC4);
    txe_n = 1'b0;
    repeat (30) tick();
    check("arb_sequence", int'(seq), 16'h0019);
    check("arb_tx_used", int'(wrusedw), 0);
    check("arb_rx_used", int'(rdusedw), 4);
    pause_at = -1;
    drain_rx();

    // TX full: ninth push is dropped
    txe_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b = 8'hE0 + 8'(i);
      push_tx(b, i < 8);
    end
    check("full_flag", int'(wrfull), 1);
    check("full_used", int'(wrusedw), 8);
    push_tx(8'hEE, 1'b0);
    check("full_push_ignored", int'(wrusedw), 8);
    base = wr_cycles;
    txe_n = 1'b0;
    repeat (14) tick();
    check("full_drain_cycles", wr_cycles - base, 8);
    check("full_drain_used", int'(wrusedw), 0);
    check("full_drain_flag", int'(wrfull), 0);

    check("exp_tx_left", exp_tx.size(), 0);
    check("exp_rx_left", exp_rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_ft232h_if.md
# usb_ft232h_if

Bridge between an FTDI FT232H in 245 synchronous-FIFO mode and the FPGA's internal byte streams. Receive and transmit FIFOs buffer traffic in both directions, and a small arbiter drives the FT232H handshake pins. Everything runs on the 60 MHz clock supplied by the FT232H. Internal logic reads received bytes from one FIFO port and queues transmit bytes on the other.

## Interface
- DEPTH, 512: entries per FIFO; must be a power of two, ≥4.
- CW, $clog2(DEPTH)+1: width of the used-word counters, covering 0..DEPTH.

Ports:
- usb_clk_i  in  1  60 MHz FT232H CLKOUT; the only clock. All logic is on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- usb_data_io  inout  8  FT232H ADBUS.
- usb_rxf_n_i  in  1  low when the chip holds received data.
- usb_txe_n_i  in  1  low when the chip can accept data.
- usb_rd_n_o  out  1  read strobe, active low.
- usb_wr_n_o  out  1  write strobe, active low.
- usb_oe_n_o  out  1  FT232H output enable, active low.
- rxf_rdreq_i  in  1  pops one RX byte.
- rxf_rddata_o  out  8  RX head byte (first-word fall-through).
- rxf_rdusedw_o  out  CW  RX occupancy.
- txe_wrreq_i  in  1  pushes txe_wrdata_i.
- txe_wrdata_i  in  8  TX byte.
- txe_wrusedw_o  out  CW  TX occupancy.
- txe_wrfull_o  out  1  high when TX occupancy = DEPTH.

## Operation
- FSM states: IDLE, RD_OE, RD, TURN, WR. The outputs decode directly from the state register:
  - usb_oe_n_o = 0 in RD_OE and RD.
  - usb_rd_n_o = 0 in RD.
  - usb_wr_n_o = 0 in WR.
  - usb_data_io is driven with the TX head only in WR; otherwise it is high-Z.
- rx_ok = !usb_rxf_n_i && (DEPTH − rx_used ≥ 2). tx_ok = !usb_txe_n_i && tx_used ≥ 1.
- IDLE:
  - If rx_ok and (!tx_ok or last=WRITE), go to RD_OE.
  - Else if tx_ok, go to WR.
  - `last` is a flag set on entry to RD_OE (READ) or WR (WRITE), giving round-robin arbitration.
- RD_OE always goes to RD after one cycle.
- RD:
  - At each edge where usb_rxf_n_i = 0, push usb_data_io into the RX FIFO.
  - Stay in RD while rx_ok, evaluated with the occupancy before this edge's push. Otherwise go to TURN.
- TURN always goes to IDLE after one cycle. This is the bus turnaround; the chip OE and the FPGA driver are never both active.
- WR:
  - At each edge where usb_txe_n_i = 0, the byte is accepted: pop the TX FIFO.
  - If usb_txe_n_i = 1, no pop occurs and the same byte stays on the bus.
  - Stay in WR while usb_txe_n_i = 0 and the occupancy after this edge's pop is ≥ 1. Otherwise go to IDLE.
- User RX port:
  - rxf_rddata_o is valid whenever rxf_rdusedw_o > 0.
  - rxf_rdreq_i while empty is ignored.
- User TX port: txe_wrreq_i while full is ignored; data is dropped and state is unchanged.
- A simultaneous push and pop on the same FIFO is legal. The count is unchanged and the data is ordered correctly.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_i high at an edge): state IDLE, last=WRITE, all strobes 1, usb_data_io high-Z, both FIFOs empty, rdusedw=0, wrusedw=0, wrfull=0, rddata=don't-care. Reset applied mid-burst aborts the burst in the next cycle and discards FIFO contents.
- Read burst: IDLE → RD_OE costs 1 cycle of OE# alone before RD#. The first byte is pushed at the edge ending the first RD# low cycle. After that, one byte per clock.
- A received byte is visible on rxf_rddata_o and counted in rxf_rdusedw_o the cycle after capture.
- The RX FIFO never overflows. RD# deasserts while ≥1 slot is still free.
- A TX byte written at edge k can be on the bus no earlier than the cycle after edge k+1: the count update, then WR entry.
- The TX used count falls in the cycle after each accepted byte.
- Total TX throughput is one byte per clock while TXE# stays low.

## Structure
- Package usb_ft232h_pkg: state enum (IDLE, RD_OE, RD, TURN, WR) and the DEPTH default constant.
- One sub-module, sync_fifo:
  - Parameterised width and depth; single clock; synchronous active-high reset.
  - FWFT head output, used count, full flag.
  - Push/pop with ignore-on-full/empty.
  - Instantiated twice, once for RX and once for TX.

## Test plan
- Reset: hold rst_i for 3 clocks → all strobes 1, bus high-Z, both usedw=0, wrfull=0.
- RX burst: the chip model presents A1,A2,A3,A4 with RXF# low, then raises RXF# → OE# low then RD# low one cycle later, 4 bytes captured, TURN cycle, rdusedw=4; four rdreq pops return A1..A4.
- TX burst: push 10,20,30 with TXE# low → WR# low for exactly 3 cycles with bus 10,20,30, then IDLE; wrusedw returns to 0.
- TXE# stall: TXE# goes high mid-burst for 2 cycles → the same byte is held on the bus, no pop, and the burst resumes without loss or duplication.
- RX backpressure with DEPTH=8 and a continuous RXF# low: RD# deasserts when rdusedw reaches 8 with no overflow. Popping 2 bytes leads to a new burst.
- Arbitration: RXF# and TXE# both low with TX data queued → read and write bursts alternate, starting with read after reset. Pushing while wrfull=1 leaves wrusedw=DEPTH.
